// File: rtl/dcache_pkg.sv
// Shared types and constants for the L1 data-cache controller.
// Tag entry layout is {valid, dirty, tag[22:0]}.
package dcache_pkg;

  localparam int TAG_W     = 23;
  localparam int IDX_W     = 4;
  localparam int LINE_W    = 256;
  localparam int WORD_W    = 32;
  localparam int OFF_W     = 5;
  localparam int ENT_W     = 25;
  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    REFILL
  } state_t;

  function automatic logic [31:0] line_addr(
    input logic [TAG_W-1:0] tag,
    input logic [IDX_W-1:0] idx
  );
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_word_mux.sv
// Word select for loads and word insert for stores
// within one 256-bit cache line.
module dcache_word_mux
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [2:0]        sel,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic [LINE_W-1:0] merged
);

  logic [7:0] base;

  assign base = {sel, 5'b0};

  always_comb begin
    rdata  = line[base +: WORD_W];
    merged = line;
    merged[base +: WORD_W] = wdata;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// 2-way L1 data-cache controller: hit, writeback, refill sequencing.
// Define DCACHE_STATS_EN to build the hit/miss statistics counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [ENT_W-1:0]  sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  input  logic [ENT_W-1:0]  sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  state_t state, nxt;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  vtag;
  logic [LINE_W-1:0] vline;
  logic [LINE_W-1:0] merged;
  logic              unused;

  assign tag    = cpu_addr_i[31:9];
  assign idx    = cpu_addr_i[8:5];
  assign unused = ^cpu_addr_i[1:0];

  dcache_word_mux u_mux (
    .line   (sram_data_i),
    .sel    (cpu_addr_i[4:2]),
    .wdata  (cpu_data_i),
    .rdata  (cpu_data_o),
    .merged (merged)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      vtag  <= '0;
      vline <= '0;
    end else begin
      state <= nxt;
      if (state == MISS) begin
        vtag  <= sram_tag_i[TAG_W-1:0];
        vline <= sram_data_i;
      end
    end
  end

  always_comb begin
    nxt          = state;
    sram_write_o = 1'b0;
    sram_tag_o   = '0;
    sram_data_o  = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = line_addr(tag, idx);
    unique case (state)
      IDLE: begin
        if (cpu_req_i) begin
          if (!sram_hit_i) begin
            nxt = MISS;
          end else if (cpu_write_i) begin
            sram_write_o = 1'b1;
            sram_tag_o   = {1'b1, 1'b1, tag};
            sram_data_o  = merged;
          end
        end
      end
      MISS: begin
        if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT])
          nxt = WRITEBACK;
        else
          nxt = READMISS;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = line_addr(vtag, idx);
        if (mem_ack_i) nxt = READMISS;
      end
      READMISS: begin
        mem_enable_o = 1'b1;
        if (mem_ack_i) begin
          sram_write_o = 1'b1;
          sram_tag_o   = {1'b1, 1'b0, tag};
          sram_data_o  = mem_data_i;
          nxt          = REFILL;
        end
      end
      REFILL: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign sram_enable_o = sram_write_o;
  assign sram_addr_o   = idx;
  assign mem_data_o    = vline;
  assign cpu_stall_o   = cpu_req_i &
                         ((state != IDLE) | !sram_hit_i);

`ifdef DCACHE_STATS_EN
  logic [31:0] hits;
  logic [31:0] misses;
  logic        refilled;

  // a hit right after a refill finishes a miss, not a new hit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hits     <= '0;
      misses   <= '0;
      refilled <= 1'b0;
    end else begin
      if (state == IDLE && cpu_req_i) begin
        if (sram_hit_i) begin
          if (!refilled && hits != 32'hFFFF_FFFF)
            hits <= hits + 32'd1;
          refilled <= 1'b0;
        end else if (misses != 32'hFFFF_FFFF) begin
          misses <= misses + 32'd1;
        end
      end
      if (state == REFILL) refilled <= 1'b1;
    end
  end

  assign hit_cnt_o  = hits;
  assign miss_cnt_o = misses;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl with a 2-way SRAM model, a line memory
// responder and a word-level golden memory / LRU-list cache model.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_write;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         sram_en, sram_wr;
  logic [3:0]   sidx;
  logic [24:0]  sram_tag_o, rtag;
  logic [255:0] sram_wdata, rline;
  logic         hit;
  logic         mem_en, mem_wr;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         spur;
  logic [31:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu_req_i     (cpu_req),
    .cpu_write_i   (cpu_write),
    .cpu_addr_i    (cpu_addr),
    .cpu_data_i    (cpu_wdata),
    .cpu_data_o    (cpu_rdata),
    .cpu_stall_o   (cpu_stall),
    .sram_enable_o (sram_en),
    .sram_write_o  (sram_wr),
    .sram_addr_o   (sidx),
    .sram_tag_o    (sram_tag_o),
    .sram_data_o   (sram_wdata),
    .sram_tag_i    (rtag),
    .sram_data_i   (rline),
    .sram_hit_i    (hit),
    .mem_enable_o  (mem_en),
    .mem_write_o   (mem_wr),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_wdata),
    .mem_data_i    (mem_rdata),
    .mem_ack_i     (mem_ack | spur),
    .hit_cnt_o     (hit_cnt),
    .miss_cnt_o    (miss_cnt)
  );

  int total = 0;
  int bad = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // backing memory, line granular
  logic [255:0] mem_m [logic [31:0]];

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem_m.exists(la)) return mem_m[la];
    l = '0;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  // SRAM model: two ways, LRU pointer per set
  logic [24:0]  tag_m  [2][16];
  logic [255:0] data_m [2][16];
  logic         lru_m  [16];
  logic         hitw, way;
  logic         sram_clr;

  always_comb begin
    hit  = 1'b0;
    hitw = 1'b0;
    for (int w = 0; w < 2; w++)
      if (tag_m[w][sidx][24] &&
          tag_m[w][sidx][22:0] == cpu_addr[31:9]) begin
        hit  = 1'b1;
        hitw = w[0];
      end
    way   = hit ? hitw : lru_m[sidx];
    rtag  = tag_m[way][sidx];
    rline = data_m[way][sidx];
  end

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int s = 0; s < 16; s++) begin
        lru_m[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          tag_m[w][s]  <= '0;
          data_m[w][s] <= '0;
        end
      end
    end else begin
      if (cpu_req && !cpu_stall && hit) lru_m[sidx] <= ~hitw;
      if (sram_en && sram_wr) begin
        tag_m[way][sidx]  <= sram_tag_o;
        data_m[way][sidx] <= sram_wdata;
        lru_m[sidx]       <= ~way;
      end
    end
  end

  // memory responder: ack after mem_lat cycles of enable
  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mtx_t;

  mtx_t mlog [$];
  int   mem_lat = 10;
  int   cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      cnt     = 0;
    end else begin
      mem_ack = 1'b0;
      if (mem_en) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt     = 0;
          mem_ack = 1'b1;
          mlog.push_back('{mem_wr, mem_addr, mem_wdata});
          if (mem_wr) mem_m[mem_addr] = mem_wdata;
          else mem_rdata = mem_line(mem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // reference: golden words plus per-set MRU-first line lists
  logic [31:0] gold    [logic [31:0]];
  bit          dirty_m [logic [31:0]];
  logic [31:0] sets    [16][$];
  int          hit_n = 0;
  int          miss_n = 0;

  function automatic logic [31:0] gword(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  function automatic logic [255:0] gline(input logic [31:0] la);
    logic [255:0] l;
    l = '0;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = gword(la + 32'(w * 4));
    return l;
  endfunction

  task automatic model_access(
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output bit          mhit,
    output bit          wb,
    output logic [31:0] va,
    output logic [31:0] data
  );
    logic [31:0] ln;
    int s, pos;
    ln  = {a[31:5], 5'b0};
    s   = int'(a[8:5]);
    pos = -1;
    for (int i = 0; i < sets[s].size(); i++)
      if (sets[s][i] == ln) pos = i;
    mhit = (pos >= 0);
    wb   = 1'b0;
    va   = '0;
    if (mhit) begin
      hit_n++;
      sets[s].delete(pos);
    end else begin
      miss_n++;
      if (sets[s].size() == 2) begin
        va = sets[s][1];
        wb = dirty_m.exists(va) && dirty_m[va];
        dirty_m[va] = 1'b0;
        sets[s].delete(1);
      end
      dirty_m[ln] = 1'b0;
    end
    sets[s].push_front(ln);
    if (wr) dirty_m[ln] = 1'b1;
    data = gword(a);
    if (wr) gold[a] = d;
  endtask

  task automatic chk(
    input string        n,
    input logic [255:0] act,
    input logic [255:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // call at posedge+1; returns at posedge+1 after completion
  task automatic run_access(
    input string        nm,
    input logic         wr,
    input logic [31:0]  a,
    input logic [31:0]  d,
    input int           exp_stall,
    input bit           exp_wb,
    input logic [31:0]  wb_a,
    input logic [255:0] wb_d,
    input bit           exp_rd,
    input logic [31:0]  rd_a,
    input bit           chk_d,
    input logic [31:0]  exp_d
  );
    int   st, viol, base, n;
    logic [31:0] got;
    mtx_t m;
    base      = mlog.size();
    cpu_req   = 1'b1;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    st   = 0;
    viol = 0;
    forever begin
      @(negedge clk);
      if (sram_en !== sram_wr) viol++;
      if (!cpu_stall) break;
      st++;
      if (st > 3000) break;
    end
    got = cpu_rdata;
    chk({nm, " stall"}, st, exp_stall);
    chk({nm, " sram_en"}, viol, 0);
    if (chk_d) chk({nm, " rdata"}, got, exp_d);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    n = mlog.size() - base;
    chk({nm, " memops"}, n, int'(exp_wb) + int'(exp_rd));
    if (exp_wb && n >= 1) begin
      m = mlog[base];
      chk({nm, " wb_wr"}, m.wr, 1);
      chk({nm, " wb_addr"}, m.addr, wb_a);
      chk({nm, " wb_data"}, m.data, wb_d);
    end
    if (exp_rd && n >= 1) begin
      m = mlog[mlog.size() - 1];
      chk({nm, " rd_wr"}, m.wr, 0);
      chk({nm, " rd_addr"}, m.addr, rd_a);
    end
  endtask

  task automatic rand_access(input string nm, input logic wr,
                             input logic [31:0] a, input logic [31:0] d);
    bit mh, wb;
    logic [31:0] va, ed;
    logic [255:0] vd;
    int es;
    model_access(wr, a, d, mh, wb, va, ed);
    vd = wb ? mem_line(va) : '0;
    if (wb) vd = gline(va);
    es = mh ? 0 : 3 + mem_lat + (wb ? mem_lat : 0);
    run_access(nm, wr, a, d, es, wb, va, vd, !mh,
               {a[31:5], 5'b0}, !wr, ed);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    bit          wb;
    logic [31:0] wb_a;
    bit          rd;
    logic [31:0] rd_a;
    bit          chk_d;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tbl [7];

  initial begin
    bit mh, wb;
    logic [31:0] va, ed, a;
    logic [255:0] wd;
    int seen;

    tbl[0] = '{0, 32'h40,  0, 13, 0, 0, 1, 32'h40,
               1, init_word(32'h40)};
    tbl[1] = '{1, 32'h44,  32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 32'h44,  0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF};
    tbl[3] = '{0, 32'h48,  0, 0, 0, 0, 0, 0, 1, init_word(32'h48)};
    tbl[4] = '{0, 32'h240, 0, 13, 0, 0, 1, 32'h240,
               1, init_word(32'h240)};
    tbl[5] = '{0, 32'h440, 0, 23, 1, 32'h40, 1, 32'h440,
               1, init_word(32'h440)};
    tbl[6] = '{0, 32'h44,  0, 13, 0, 0, 1, 32'h40, 1, 32'hDEAD_BEEF};

    rst = 1'b1;
    sram_clr = 1'b1;
    spur = 1'b0;
    cpu_req = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst sram_wr", sram_wr, 0);
    chk("rst hit_cnt", hit_cnt, 0);
    chk("rst miss_cnt", miss_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sram_clr = 1'b0;

    mem_lat = 10;
    foreach (tbl[i]) begin
      wd = gline(tbl[i].wb_a);
      model_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                   mh, wb, va, ed);
      run_access($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr,
                 tbl[i].wdata, tbl[i].stall, tbl[i].wb, tbl[i].wb_a,
                 wd, tbl[i].rd, tbl[i].rd_a, tbl[i].chk_d,
                 tbl[i].exp_d);
    end

    // store hit: same-cycle SRAM write with one word replaced
    model_access(1'b1, 32'h48, 32'h1234_5678, mh, wb, va, ed);
    cpu_req = 1'b1;
    cpu_write = 1'b1;
    cpu_addr = 32'h48;
    cpu_wdata = 32'h1234_5678;
    #1;
    chk("st stall", cpu_stall, 0);
    chk("st sram_wr", sram_wr, 1);
    chk("st sram_en", sram_en, 1);
    chk("st tag", sram_tag_o, {2'b11, 23'h0});
    chk("st line", sram_wdata, gline(32'h40));
    @(posedge clk);
    #1;
    cpu_req = 1'b0;

    // spurious ack in idle
    spur = 1'b1;
    @(negedge clk);
    chk("spur sram_wr", sram_wr, 0);
    chk("spur mem_en", mem_en, 0);
    @(posedge clk);
    #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur after mem_en", mem_en, 0);
    @(posedge clk);
    #1;
    rand_access("spur hit", 1'b0, 32'h40, 0);

    // reset while READMISS is waiting on memory
    mem_lat = 1000;
    cpu_req = 1'b1;
    cpu_write = 1'b0;
    cpu_addr = 32'h840;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_en && !mem_wr) seen = 1;
    end
    chk("rm reached", seen, 1);
    rst = 1'b1;
    #1;
    chk("rm rst mem_en", mem_en, 0);
    chk("rm rst mem_wr", mem_wr, 0);
    chk("rm rst sram_wr", sram_wr, 0);
    cpu_req = 1'b0;
    hit_n = 0;
    miss_n = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b1;
    cpu_addr = 32'h44;
    #1;
    chk("rm idle probe", cpu_stall, 0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    mem_lat = 4;
    rand_access("rm retry", 1'b0, 32'h840, 0);

    rand_access("stat h1", 1'b0, 32'h840, 0);
    rand_access("stat h2", 1'b0, 32'h844, 0);
    rand_access("stat h3", 1'b0, 32'h848, 0);
    @(negedge clk);
`ifdef DCACHE_STATS_EN
    chk("stat miss", miss_cnt, 1);
    chk("stat hit", hit_cnt, 3);
`else
    chk("stat miss", miss_cnt, 0);
    chk("stat hit", hit_cnt, 0);
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
          ($urandom_range(0, 7) << 2);
      mem_lat = int'($urandom_range(1, 5));
      rand_access($sformatf("rnd%0d", i), ($urandom_range(0, 9) < 4),
                  a, $urandom);
    end

    @(negedge clk);
`ifdef DCACHE_STATS_EN
    chk("final miss", miss_cnt, miss_n);
    chk("final hit", hit_cnt, hit_n);
`else
    chk("final miss", miss_cnt, 0);
    chk("final hit", hit_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Controller sequencing the 2-way set-associative L1 data-cache SRAM (16 sets, 256-bit lines, 25-bit tag entry {valid, dirty, tag[22:0]}) between the CPU load/store port and the line-wide data memory. It resolves hits in the request cycle, stalls the CPU on a miss, writes back a dirty victim, refills the line and then completes the access. It instantiates nothing external; the SRAM and data memory sit beside it in the CPU top level.

## Interface
- TAG_W, 23, address tag width (addr[31:9])
- IDX_W, 4, set index width (addr[8:5])
- LINE_W, 256, line width in bits; word select is addr[4:2]
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- cpu_req_i  in  1  load/store request; requester holds req/addr/data/write stable while cpu_stall_o=1
- cpu_write_i  in  1  1=store, 0=load
- cpu_addr_i  in  32  byte address, word aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, valid when req & !stall
- cpu_stall_o  out  1  stall CPU
- sram_enable_o / sram_write_o  out  1 each  SRAM enable / write strobe
- sram_addr_o  out  IDX_W  set index
- sram_tag_o  out  25  {valid, dirty, tag} written
- sram_data_o  out  LINE_W  line written
- sram_tag_i  in  25  hit way's tag entry, else LRU victim's
- sram_data_i  in  LINE_W  matching line data
- sram_hit_i  in  1  tag hit
- mem_enable_o / mem_write_o  out  1 each  memory request / write
- mem_addr_o  out  32  line-aligned address (addr[4:0]=0)
- mem_data_o  out  LINE_W  writeback line
- mem_data_i  in  LINE_W  refill line, valid on mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse
- hit_cnt_o / miss_cnt_o  out  32 each  statistics (see Configuration)

## Operation
- sram_addr_o = cpu_addr_i[8:5] always; lookup tag = cpu_addr_i[31:9].
- States: IDLE, MISS, WRITEBACK, READMISS, REFILL.
- IDLE: req & hit → load: cpu_data_o = sram_data_i word [addr[4:2]]; store: SRAM write of sram_data_i with that word replaced by cpu_data_i, tag {1,1,tag}. req & !hit → MISS.
- MISS (1 cycle): victim dirty (sram_tag_i[24]&[23]) → WRITEBACK; else → READMISS. Victim tag and line latched here.
- WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=latched line; on mem_ack_i → READMISS.
- READMISS: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; on mem_ack_i SRAM write of mem_data_i with tag {1,0,cpu tag} in that same cycle, → REFILL.
- REFILL (1 cycle, no SRAM write) → IDLE, where the access completes as a hit.
- mem_ack_i outside WRITEBACK/READMISS ignored.

## Timing
- cpu_stall_o = cpu_req_i & (state≠IDLE | !sram_hit_i), combinational.
- Hit: zero stall cycles. Clean miss: stall = 3 + N cycles (N = cycles from READMISS entry to ack). Dirty miss adds WRITEBACK wait.
- mem_enable_o, mem_write_o are state decodes; held high until mem_ack_i, drop the cycle after.
- Reset (any state, mid-transaction): state→IDLE, mem_enable_o=0, mem_write_o=0, sram_write_o=0, latched victim cleared, counters 0; in-flight memory transaction abandoned (memory is reset together).
- sram_enable_o=1 only in cycles with an SRAM write.

## Configuration
- DCACHE_STATS_EN defined: hit_cnt_o increments on each IDLE access with hit and no preceding miss for it; miss_cnt_o increments on each IDLE→MISS transition; both saturate at 32'hFFFF_FFFF.
- Undefined: counter logic absent, both ports tied to 0.

## Structure
- dcache_pkg: state enum, TAG_W/IDX_W/LINE_W, tag bit positions (VALID_BIT=24, DIRTY_BIT=23), line-address helper constants.
- One sub-module: dcache_word_mux (combinational word select for loads and word insert for stores); the FSM stays in dcache_ctrl.

## Test plan
- Cold load 0x0000_0040, SRAM empty → MISS, READMISS with mem_addr_o=0x40, ack after 10 cycles → refill tag {1,0,0}, stall drops in IDLE, cpu_data_o = word 0 of refill line.
- Store hit 0x44 data 0xDEAD_BEEF → same-cycle SRAM write, word 1 replaced, tag dirty=1, stall never asserted.
- Third tag to set 2 with dirty LRU victim → WRITEBACK to victim line address with victim data, then READMISS of new line; order checked.
- rst_i asserted in READMISS with mem_enable_o=1 → mem_enable_o=0 immediately, state IDLE, a later identical request restarts at MISS.
- Spurious mem_ack_i in IDLE → no state change, no SRAM write.
- With DCACHE_STATS_EN: 1 miss then 3 hits → miss_cnt_o=1, hit_cnt_o=3; without macro both read 0.
